seq_pattern_gen: RTL and testbench



---
 rtl/seq_gen_pkg.sv | 17 +
 rtl/seq_gen_shreg.sv | 47 ++++
 rtl/seq_pattern_gen.sv | 183 ++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared state encodings and width helper for the serial pattern generator.
package seq_gen_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE   = 3'd0;
    localparam seq_state_t ST_SHIFT  = 3'd1;
    localparam seq_state_t ST_GAP    = 3'd2;
    localparam seq_state_t ST_FIN    = 3'd3;
    localparam seq_state_t ST_PARITY = 3'd4;

    // Width able to hold any length 0..PAT_W.
    function automatic int seq_len_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable left-aligned shift register with a remaining-bit down-counter.
// The caller emits din[PAT_W-1] itself on load; msb is the next bit, last_bit means no bits remain.
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = seq_len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    input  logic [LEN_W-1:0] len,
    output logic             msb,
    output logic             last_bit
);

    logic [PAT_W-1:0] sr_q, sr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = din << 1;
            cnt_d = len - LEN_W'(1);
        end else if (shift) begin
            sr_d  = sr_q << 1;
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign msb      = sr_q[PAT_W-1];
    assign last_bit = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial MSB-first pattern transmitter with repeat passes, idle gaps and a done pulse.
// SEQ_PATTERN_GEN_PARITY_EN appends an even-parity bit after every pass.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int  PAT_W   = 8,
    parameter int  CNT_W   = 4,
    parameter int  GAP_CYC = 0,
    localparam int LEN_W   = seq_len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
    localparam int               GAP_W   = 16;

    seq_state_t       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d, eff_len;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             x_q, x_d, x_valid_q, x_valid_d;
    logic             ready_q, ready_d, done_q, done_d;
    logic             sr_load, sr_shift, sr_msb, sr_last;
    logic [PAT_W-1:0] sr_din;
    logic [LEN_W-1:0] sr_len;
    logic             pass_end, reload;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    logic             par_q, par_d;
`endif

    assign eff_len = (len == '0 || len > PAT_W_L) ? PAT_W_L : len;

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        rep_d    = rep_q;
        gap_d    = gap_q;
        x_d      = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_din   = pat_q;
        sr_len   = len_q;
        pass_end = 1'b0;
        reload   = 1'b0;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start && !abort) begin
                    // Pattern is stored left-aligned so every pass starts at bit PAT_W-1.
                    pat_d  = pattern << (PAT_W_L - eff_len);
                    len_d  = eff_len;
                    rep_d  = repeat_n;
                    reload = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!sr_last) begin
                    x_d      = sr_msb;
                    sr_shift = 1'b1;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                    par_d    = par_q ^ sr_msb;
`endif
                end else begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                    state_d = ST_PARITY;
                    x_d     = par_q;
`else
                    pass_end = 1'b1;
`endif
                end
            end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            ST_PARITY: pass_end = 1'b1;
`endif
            ST_GAP: begin
                if (gap_q == '0) reload = 1'b1;
                else             gap_d  = gap_q - GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (pass_end) begin
            if (rep_q == '0) begin
                state_d = ST_FIN;
            end else begin
                rep_d = rep_q - CNT_W'(1);
                if (GAP_CYC == 0) begin
                    reload = 1'b1;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = GAP_W'(GAP_CYC - 1);
                end
            end
        end

        if (reload) begin
            state_d = ST_SHIFT;
            sr_load = 1'b1;
            sr_din  = pat_d;
            sr_len  = len_d;
            x_d     = pat_d[PAT_W-1];
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            par_d   = pat_d[PAT_W-1];
`endif
        end

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            x_d     = 1'b0;
        end
    end

    always_comb begin
        x_valid_d = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
        ready_d   = (state_d == ST_IDLE) || (state_d == ST_FIN);
        done_d    = (state_d == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    seq_gen_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .shift    (sr_shift),
        .din      (sr_din),
        .len      (sr_len),
        .msb      (sr_msb),
        .last_bit (sr_last)
    );

    assign ready   = ready_q;
    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: stimulus queues timed expected bits/done pulses, a monitor pops and compares.
module tb_seq_pattern_gen;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;
    localparam int GAP   = 2;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic [3:0] repeat_n = '0;
    logic       ready, x, x_valid, done;

    typedef struct {
        bit   is_done;
        logic v;
        int   cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         det_cnt = 0;
    logic [2:0] hist = '0;
    bit         mon_en = 1'b0;

    seq_pattern_gen #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .GAP_CYC (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
        .repeat_n (repeat_n),
        .abort    (abort),
        .ready    (ready),
        .x        (x),
        .x_valid  (x_valid),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every output event against the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_%s got nothing by cyc %0d, required at cyc %0d",
                         mon_e.is_done ? "done" : "bit", cyc, mon_e.cyc);
            end
            if (x_valid === 1'b1 || done === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output cyc=%0d got x_valid=%b x=%b done=%b, required no output",
                             cyc, x_valid, x, done);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.cyc != cyc || done !== mon_e.is_done || x_valid !== !mon_e.is_done ||
                        (!mon_e.is_done && x !== mon_e.v)) begin
                        n_bad++;
                        $display("FAIL stream cyc=%0d got x_valid=%b x=%b done=%b, required cyc=%0d %s x=%b",
                                 cyc, x_valid, x, done, mon_e.cyc, mon_e.is_done ? "done" : "bit", mon_e.v);
                    end
                end
            end else begin
                n_cmp++;
                if (x !== 1'b0) begin
                    n_bad++;
                    $display("FAIL x_idle cyc=%0d got x=%b, required 0", cyc, x);
                end
            end
            if (x_valid === 1'b1) begin
                if (hist == 3'b101 && x === 1'b1) det_cnt++;
                hist = {hist[1:0], x};
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Issue a request now (cycle N); queue up to n_keep bit events plus an optional done event.
    task automatic issue(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rep,
                         input logic [7:0] exp_bits, input int nb, input logic exp_par,
                         input int n_keep, input bit exp_done);
        int n0;
        int off;
        int pushed;
        n0 = cyc;
        off = 1;
        pushed = 0;
        start = 1'b1;
        pattern = pat;
        len = ln;
        repeat_n = rep;
        for (int p = 0; p <= int'(rep); p++) begin
            for (int i = nb - 1; i >= 0; i--) begin
                if (pushed < n_keep) sb.push_back('{1'b0, exp_bits[i], n0 + off});
                pushed++;
                off++;
            end
            if (PB == 1) begin
                if (pushed < n_keep) sb.push_back('{1'b0, exp_par, n0 + off});
                pushed++;
                off++;
            end
            if (p < int'(rep)) off += GAP;
        end
        if (exp_done) sb.push_back('{1'b1, 1'b0, n0 + off});
        @(posedge clk); #1;
        start = 1'b0;
        pattern = ~pat;
        len = 4'd1;
        repeat_n = 4'd7;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout got %0d pending events, required 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog got no completion by cyc %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_x", x, 0);
        check("rst_x_valid", x_valid, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // 0x0B len 4 once: 1011, done at N+5
        issue(8'h0B, 4'd4, 4'd0, 8'b0000_1011, 4, 1'b1, 1000, 1'b1);
        check("t1_busy_ready", ready, 0);
        repeat (4 + PB) @(posedge clk);
        #1;
        check("t1_done_ready", ready, 1);
        drain("t1");
        check("t1_detect_1011", det_cnt, 1);

        // Three passes with gaps; stray starts mid-transfer must be ignored
        issue(8'h0B, 4'd4, 4'd2, 8'b0000_1011, 4, 1'b1, 1000, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; pattern = 8'hFF; len = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        check("t2_busy_ready", ready, 0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain("t2");

        // len=0 means full width; back-to-back start in the done cycle
        issue(8'hA5, 4'd0, 4'd0, 8'b1010_0101, 8, 1'b0, 1000, 1'b1);
        repeat (8 + PB) @(posedge clk);
        #1;
        check("t3_done", done, 1);
        check("t3_done_ready", ready, 1);
        issue(8'h0B, 4'd4, 4'd0, 8'b0000_1011, 4, 1'b1, 1000, 1'b1);
        drain("t3");

        // len above PAT_W clamps to PAT_W
        issue(8'h3C, 4'd12, 4'd0, 8'b0011_1100, 8, 1'b0, 1000, 1'b1);
        drain("t4");

        // Single-bit pass repeated once; upper pattern bits are masked
        issue(8'hFE, 4'd1, 4'd1, 8'b0000_0000, 1, 1'b0, 1000, 1'b1);
        drain("t5");

        // Abort after the 2nd bit
        issue(8'h0B, 4'd4, 4'd0, 8'b0000_1011, 4, 1'b1, 2, 1'b0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t6_abort_ready", ready, 1);
        check("t6_abort_x_valid", x_valid, 0);
        check("t6_abort_x", x, 0);
        repeat (6) @(posedge clk);
        #1;

        // Abort together with start in IDLE: nothing sent
        start = 1'b1; abort = 1'b1; pattern = 8'h0B; len = 4'd4; repeat_n = 4'd0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("t7_ready", ready, 1);
        repeat (8) @(posedge clk);
        #1;

        // Reset during the 3rd bit, then a normal request
        issue(8'h0B, 4'd4, 4'd0, 8'b0000_1011, 4, 1'b1, 3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t8_rst_ready", ready, 1);
        check("t8_rst_x", x, 0);
        check("t8_rst_x_valid", x_valid, 0);
        check("t8_rst_done", done, 0);
        issue(8'hA5, 4'd8, 4'd0, 8'b1010_0101, 8, 1'b0, 1000, 1'b1);
        drain("t8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
